// File: rtl/shift_r_int16_iter.sv
// Iterative barrel right shifter. Stage k shifts by 2^k when amount bit k is set,
// so every operation takes SHIFT_WIDTH stage cycles no matter what the amount is.
module shift_r_int16_iter #(
  parameter int WIDTH       = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [SHIFT_WIDTH-1:0] LAST_STAGE = SHIFT_WIDTH'(SHIFT_WIDTH - 1);

  state_e                 state_q;
  logic [SHIFT_WIDTH-1:0] cnt_q;
  logic [SHIFT_WIDTH-1:0] amt_q;
  logic                   mode_q;
  logic [WIDTH-1:0]       work_q;
  logic [WIDTH-1:0]       work_d;
  logic [WIDTH-1:0]       y_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [SHIFT_WIDTH-1:0] stage_dist;

  // Only the low amount bits select stages; the rest of B is deliberately dropped.
  logic unused_b_hi;
  assign unused_b_hi = ^B[WIDTH-1:SHIFT_WIDTH];

  // The work register keeps the captured sign in its MSB under arithmetic mode,
  // so sign-filling from work_q is the same as filling from the original A MSB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    work_d     = work_q;
    stage_dist = SHIFT_WIDTH'(1) << cnt_q;
    if (amt_q[cnt_q]) begin
      if (mode_q) work_d = WIDTH'($signed(work_q) >>> stage_dist);
      else        work_d = work_q >> stage_dist;
    end
  end

  // NOTE: all state, including the data registers, is asynchronously reset so an
  // aborted operation can never leak a stale value onto Y after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      amt_q       <= '0;
      mode_q      <= 1'b0;
      work_q      <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= A;
            amt_q      <= B[SHIFT_WIDTH-1:0];
            mode_q     <= arith;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STAGE) begin
            y_q         <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y         = y_q;

endmodule

// File: tb/tb_shift_r_int16_iter.sv
// Self-checking bench for shift_r_int16_iter: directed corner cases followed by a
// long randomized stream, all compared against a transaction-level reference model.
module tb_shift_r_int16_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Y;

  int checks = 0;
  int errors = 0;

  // Reference model: idle / busy-for-N-edges / holding-a-result.
  logic        m_busy;
  logic        m_done;
  int          m_left;
  logic [15:0] m_res;
  logic [15:0] m_y;

  shift_r_int16_iter #(.WIDTH(16), .SHIFT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic ar);
    logic [3:0] s;
    s = b[3:0];
    if (ar) return 16'($signed(a) >>> s);
    return a >> s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_left = 0;
    m_res  = '0;
    m_y    = '0;
  endtask

  task automatic model_edge();
    if (!m_busy && !m_done) begin
      if (in_valid) begin
        m_res  = golden(A, B, arith);
        m_busy = 1'b1;
        m_left = 4;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_y    = m_res;
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("in_ready",  32'(in_ready),  32'(!m_busy && !m_done));
    check("out_valid", 32'(out_valid), 32'(m_done));
    check("Y",         32'(Y),         32'(m_y));
  endtask

  // Inputs are set at the falling edge before calling; outputs are checked at the next one.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Accept one operand, scramble the inputs while it is in flight, expect the
  // result exactly four edges later, and leave the block holding it in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ar,
                        input logic [15:0] exp_y, input string tag);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    arith     = ar;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      A        = 16'($urandom);
      B        = 16'($urandom);
      arith    = 1'($urandom);
      step();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(Y), 32'(exp_y));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    int ops;
    int cyc;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_Y",         32'(Y),         32'd0);
    rst_n = 1'b1;

    run_op(16'hF0F0, 16'd4,    1'b0, 16'h0F0F, "logical_f0f0");
    drain();
    run_op(16'h8000, 16'd15,   1'b1, 16'hFFFF, "arith_8000_15");
    drain();
    run_op(16'h8000, 16'd15,   1'b0, 16'h0001, "logical_8000_15");
    drain();
    run_op(16'h1234, 16'h0010, 1'b1, 16'h1234, "amount0_upper_b");
    drain();

    // Backpressure: result must hold while new requests are ignored.
    run_op(16'hABCD, 16'd3, 1'b1, 16'hF579, "bp_result");
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      A         = 16'($urandom);
      B         = 16'($urandom);
      out_ready = 1'b0;
      step();
    end
    check("bp_held_Y", 32'(Y), 32'h0000_F579);
    out_ready = 1'b1;
    step();
    check("bp_released_in_ready", 32'(in_ready), 32'd1);

    // Accept a new operand, then abort it at stage 2 with an async reset.
    A = 16'h7FFF;
    B = 16'd1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_Y",         32'(Y),         32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // First edge after release must accept.
    run_op(16'h00F0, 16'd4, 1'b0, 16'h000F, "post_reset_accept");
    drain();
    for (int i = 0; i < 6; i++) step();

    // Randomized stream with sporadic in_valid/out_ready gaps.
    ops = 0;
    cyc = 0;
    while (ops < 10000 && cyc < 90000) begin
      in_valid  = ($urandom_range(7, 0) != 0);
      out_ready = ($urandom_range(7, 0) != 0);
      A         = 16'($urandom);
      B         = 16'($urandom);
      arith     = 1'($urandom);
      if (!m_busy && !m_done && in_valid) ops++;
      step();
      cyc++;
    end
    check("random_ops_completed", 32'(ops), 32'd10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_r_int16_iter.md
SHIFT_R_INT16_ITER -- requirements
Module: shift_r_int16_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 4, number of shift-amount bits used (log2 WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port A  input  WIDTH  value to shift.
REQ-008 SHALL have port B  input  WIDTH  shift amount; only B[SHIFT_WIDTH-1:0] used, upper bits ignored.
REQ-009 SHALL have port arith  input  1  1 = arithmetic (sign-fill) right shift, 0 = logical (zero-fill).
REQ-010 SHALL have port out_valid  output  1  result Y valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Y  output  WIDTH  shifted result.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE, plus a SHIFT_WIDTH-bit stage counter cnt.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; no overlap of input and output phases.
REQ-015 SHALL, on a rising edge with in_valid && in_ready, capture A into the work register, B[SHIFT_WIDTH-1:0] into the amount register, and arith into the mode register; set cnt=0; go to SHIFT.
REQ-016 SHALL, in IDLE with in_valid=0, hold all state.
REQ-017 SHALL, on each edge in SHIFT, apply stage cnt: if amount[cnt]=1, right-shift the work register by 2^cnt; otherwise leave it unchanged.
REQ-018 SHALL fill vacated MSBs with the captured sign bit (A[WIDTH-1]) when mode=1, else with 0.
REQ-019 SHALL increment cnt after each stage and go to DONE on the edge that applies stage SHIFT_WIDTH-1.
REQ-020 SHALL have fixed latency: out_valid rises exactly SHIFT_WIDTH (4) edges after the accepting edge, independent of the amount value, including amount 0.
REQ-021 SHALL present Y = final work register in DONE and hold Y stable while out_valid=1 && out_ready=0.
REQ-022 SHALL, on an edge in DONE with out_ready=1, return to IDLE; Y keeps its last value until the next result.
REQ-023 SHALL ignore in_valid, A, B, and arith outside IDLE; operand changes after acceptance do not affect the result.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL give a result equal to A >> B[3:0] (logical) or $signed(A) >>> B[3:0] (arithmetic) for all 2^16 x 16 x 2 inputs.
REQ-026 SHALL require 1 + SHIFT_WIDTH + 1 cycles minimum per operation (accept, shift stages, drain); back-to-back throughput is one result per 6 cycles with out_ready=1 and in_valid held at 1.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, cnt=0, work/amount/mode registers=0, Y=0, out_valid=0, in_ready=1 after release.
REQ-028 SHALL, on rst_n asserted mid-SHIFT or in DONE, discard the in-flight operation with no output handshake after release.
REQ-029 SHALL accept a new operand on the first rising edge after rst_n deasserts if in_valid=1.

Verification
REQ-030 SHALL cover logical shift: A=16'hF0F0, B=4, arith=0 -> out_valid 4 edges after accept, Y=16'h0F0F.
REQ-031 SHALL cover arithmetic shift: A=16'h8000, B=15, arith=1 -> Y=16'hFFFF; same with arith=0 -> Y=16'h0001.
REQ-032 SHALL cover amount 0 and upper-B ignore: A=16'h1234, B=16'h0010, arith=1 -> Y=16'h1234 with the same 4-cycle latency.
REQ-033 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> Y and out_valid stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low at stage 2 -> Y=0, out_valid=0 immediately; no stale result afterwards.
REQ-035 SHALL cover a randomized stream (>=10k ops, random in_valid/out_ready) checked against the REQ-025 golden model.
